// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter: pops bytes from a registered-read FIFO and serialises start, D0..D7, optional parity and stop.
// Latency: IDLE decision edge -> pop strobe next cycle -> tx falls two edges after the pop strobe rises.
// Backpressure: pops only at frame boundaries, only when tx_en=1 and the FIFO is non-empty, one pop per frame.
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic              PAR_ON    = (PARITY_EN != 0);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              can_pop;

    // Last cycle of the current serial bit.
    assign bit_end = (baud_q == BAUD_LAST);
    // A new frame may start only when enabled and there is something to pop.
    assign can_pop = tx_en && !fifo_empty;

    // State, counters, shift register and the registered line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-line logic; every register holds unless a bit boundary moves it on.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (can_pop) begin
                    state_d = POP;
                end
            end
            POP: begin
                // Pop strobe is decoded from this state; the read data arrives next cycle.
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = fifo_dout;
                par_d   = (^fifo_dout) ^ PAR_ODD;
                tx_d    = 1'b0;
                baud_d  = '0;
                bit_d   = '0;
                state_d = START;
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PAR_ON) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    done_d  = 1'b1;
                    // Back-to-back frames skip IDLE so the gap is only POP + LOAD.
                    state_d = can_pop ? POP : IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);
    assign tx         = tx_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (no parity, even, odd) fed by FIFO models.
// Latency: a line decoder samples each bit mid-period and compares against the popped bytes.
// Backpressure: tx_en is shared; each instance has its own queue and pop bookkeeping.
module tb_uart_tx_fifo_drain;

    localparam int C = 4;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic       fifo_empty [N];
    logic [7:0] fifo_dout  [N];
    logic       fifo_rd_en [N];
    logic       tx         [N];
    logic       busy       [N];
    logic       tx_done    [N];

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // FIFO model storage (write side owned by the stimulus, read side by the monitor).
    logic [7:0] fmem [N][256];
    int         fhd  [N];
    int         ftl  [N];
    // Bytes popped but not yet seen on the line, in pop order.
    logic [7:0] emem [N][256];
    int         ehd  [N];
    int         etl  [N];

    int         pops      [N];
    int         frames    [N];
    int         dones     [N];
    int         gaps      [N];
    int         pop_c     [N];
    int         fall_c    [N];
    int         last_end  [N];
    int         last_fall [N];
    int         last_done [N];
    logic [7:0] last_byte [N];
    logic       last_par  [N];
    logic       in_fr     [N];
    logic       prev_tx   [N];
    logic [10:0] bits     [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign fifo_empty[g] = (fhd[g] == ftl[g]);
        uart_tx_fifo_drain #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   ((g > 0) ? 1 : 0),
            .PARITY_ODD  ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .tx_en     (tx_en),
            .fifo_empty(fifo_empty[g]),
            .fifo_dout (fifo_dout[g]),
            .fifo_rd_en(fifo_rd_en[g]),
            .tx        (tx[g]),
            .busy      (busy[g]),
            .tx_done   (tx_done[g])
        );
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp_v);
        vectors++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, obs, obs, exp_v, exp_v, cyc);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        fmem[i][ftl[i] % 256] = b;
        ftl[i] = ftl[i] + 1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) begin
            if (fhd[i] != ftl[i] || ehd[i] != etl[i] || in_fr[i] || cyc < last_end[i] + 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step(1);
            n++;
        end
        if (!all_idle()) check("idle_timeout", 0, 1);
        for (int i = 0; i < N; i++) check($sformatf("busy_after[%0d]", i), int'(busy[i]), 0);
    endtask

    task automatic wait_fall(input int i, input int budget);
        int n;
        n = 0;
        while (!in_fr[i] && n < budget) begin
            step(1);
            n++;
        end
        if (!in_fr[i]) check("fall_timeout", 0, 1);
    endtask

    // FIFO read model plus line decoder, evaluated away from the active edge.
    always @(negedge clk) begin
        int         off;
        int         k;
        int         nb;
        logic [7:0] b;
        for (int i = 0; i < N; i++) begin
            nb = (i > 0) ? 11 : 10;
            if (!rst_n) begin
                check($sformatf("rst_tx[%0d]", i), int'(tx[i]), 1);
                check($sformatf("rst_busy[%0d]", i), int'(busy[i]), 0);
                check($sformatf("rst_rd[%0d]", i), int'(fifo_rd_en[i]), 0);
                check($sformatf("rst_done[%0d]", i), int'(tx_done[i]), 0);
                in_fr[i]    = 1'b0;
                prev_tx[i]  = 1'b1;
                ehd[i]      = etl[i];
                last_end[i] = -1;
            end else begin
                if (fifo_rd_en[i]) begin
                    check($sformatf("pop_nonempty[%0d]", i), (ftl[i] > fhd[i]) ? 1 : 0, 1);
                    check($sformatf("pop_between_frames[%0d]", i), (!in_fr[i] && cyc >= last_end[i]) ? 1 : 0, 1);
                    if (ftl[i] > fhd[i]) begin
                        fifo_dout[i]          = fmem[i][fhd[i] % 256];
                        fhd[i]                = fhd[i] + 1;
                        emem[i][etl[i] % 256] = fifo_dout[i];
                        etl[i]                = etl[i] + 1;
                    end
                    pops[i]++;
                    pop_c[i] = cyc;
                end
                if (tx_done[i]) begin
                    check($sformatf("done_time[%0d]", i), cyc, last_end[i]);
                    dones[i]++;
                    last_done[i] = cyc;
                end
                if (!in_fr[i] && prev_tx[i] && !tx[i]) begin
                    check($sformatf("pop_to_start[%0d]", i), cyc - pop_c[i], 2);
                    if (last_end[i] >= 0 && pop_c[i] == last_end[i]) begin
                        check($sformatf("gap[%0d]", i), cyc - (last_end[i] - C), C + 2);
                        gaps[i]++;
                    end
                    in_fr[i]     = 1'b1;
                    fall_c[i]    = cyc;
                    last_fall[i] = cyc;
                end else if (in_fr[i]) begin
                    off = cyc - fall_c[i];
                    if (off % C == C / 2) begin
                        k = off / C;
                        bits[i][k] = tx[i];
                        check($sformatf("busy_in_frame[%0d]", i), int'(busy[i]), 1);
                        if (k == nb - 1) begin
                            if (ehd[i] == etl[i]) begin
                                check($sformatf("frame_without_pop[%0d]", i), 0, 1);
                            end else begin
                                b      = emem[i][ehd[i] % 256];
                                ehd[i] = ehd[i] + 1;
                                check($sformatf("start_bit[%0d]", i), int'(bits[i][0]), 0);
                                check($sformatf("data[%0d]", i), int'(bits[i][8:1]), int'(b));
                                if (i > 0) check($sformatf("parity[%0d]", i), int'(bits[i][9]), int'((^b) ^ (i == 2)));
                                check($sformatf("stop_bit[%0d]", i), int'(bits[i][nb-1]), 1);
                                last_byte[i] = bits[i][8:1];
                                last_par[i]  = bits[i][9];
                            end
                            frames[i]++;
                            last_end[i] = fall_c[i] + nb * C;
                            in_fr[i]    = 1'b0;
                        end
                    end
                end
                prev_tx[i] = tx[i];
            end
        end
    end

    initial begin
        int p0;
        int f0;
        int d0;
        int g0;
        int k0;
        int cnt;
        int want [N];

        for (int i = 0; i < N; i++) begin
            fhd[i] = 0; ftl[i] = 0; ehd[i] = 0; etl[i] = 0;
            pops[i] = 0; frames[i] = 0; dones[i] = 0; gaps[i] = 0;
            pop_c[i] = -100; fall_c[i] = 0; last_end[i] = -1;
            last_fall[i] = 0; last_done[i] = 0; last_byte[i] = '0; last_par[i] = 1'b0;
            in_fr[i] = 1'b0; prev_tx[i] = 1'b1; bits[i] = '0; fifo_dout[i] = '0;
        end
        rst_n = 1'b0;
        tx_en = 1'b1;

        // Reset held with a non-empty FIFO: outputs checked every cycle by the monitor.
        step(1);
        push(0, 8'h01);
        step(8);
        check("pops_in_reset", pops[0], 0);
        rst_n = 1'b1;
        wait_idle(300);
        check("first_frame", frames[0], 1);

        // Single byte 0xAA: empty drops after edge k0, IDLE sees it at k0+1, tx falls at k0+3.
        p0 = pops[0]; f0 = frames[0]; d0 = dones[0];
        step(3);
        k0 = cyc;
        push(0, 8'hAA);
        wait_idle(300);
        check("single_pop", pops[0] - p0, 1);
        check("single_latency", last_fall[0] - k0, 3);
        check("single_frame", frames[0] - f0, 1);
        check("single_byte", int'(last_byte[0]), 8'hAA);
        check("single_done", dones[0] - d0, 1);
        check("single_len", last_done[0] - last_fall[0], 40);

        // Back-to-back frames.
        p0 = pops[0]; f0 = frames[0]; g0 = gaps[0];
        push(0, 8'hAA);
        push(0, 8'hBB);
        push(0, 8'hCC);
        wait_idle(600);
        check("b2b_pops", pops[0] - p0, 3);
        check("b2b_frames", frames[0] - f0, 3);
        check("b2b_gaps", gaps[0] - g0, 2);
        check("b2b_last", int'(last_byte[0]), 8'hCC);
        check("b2b_empty", int'(fifo_empty[0]), 1);

        // Parity: 0x07 has three ones.
        push(1, 8'h07);
        push(2, 8'h07);
        wait_idle(300);
        check("par_even_bit", int'(last_par[1]), 1);
        check("par_odd_bit", int'(last_par[2]), 0);
        check("par_even_len", last_done[1] - last_fall[1], 44);
        check("par_odd_len", last_done[2] - last_fall[2], 44);

        // Reset during D3 of 0x55; 0x66 queued during reset must be the next frame.
        push(0, 8'h55);
        wait_fall(0, 50);
        step(4 * C + 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", int'(tx[0]), 1);
        check("midrst_busy", int'(busy[0]), 0);
        p0 = pops[0]; f0 = frames[0];
        push(0, 8'h66);
        step(3);
        rst_n = 1'b1;
        wait_idle(300);
        check("midrst_pops", pops[0] - p0, 1);
        check("midrst_frames", frames[0] - f0, 1);
        check("midrst_byte", int'(last_byte[0]), 8'h66);

        // Flow control with tx_en.
        tx_en = 1'b0;
        p0 = pops[0]; f0 = frames[0];
        push(0, 8'h12);
        push(0, 8'h34);
        step(100);
        check("txen_off_pops", pops[0] - p0, 0);
        tx_en = 1'b1;
        wait_fall(0, 50);
        step(3 * C);
        tx_en = 1'b0;
        step(120);
        check("txen_drop_pops", pops[0] - p0, 1);
        check("txen_drop_frames", frames[0] - f0, 1);
        check("txen_drop_byte", int'(last_byte[0]), 8'h12);
        check("txen_drop_left", ftl[0] - fhd[0], 1);
        check("txen_drop_busy", int'(busy[0]), 0);
        tx_en = 1'b1;
        wait_idle(300);
        check("txen_resume_byte", int'(last_byte[0]), 8'h34);

        // Randomised bursts with random spacing on all three instances.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                cnt = $urandom_range(1, 4);
                want[i] = frames[i] + cnt;
                for (int j = 0; j < cnt; j++) begin
                    push(i, 8'($urandom));
                    if ($urandom_range(0, 1) == 1) step($urandom_range(1, 30));
                end
            end
            wait_idle(3000);
            for (int i = 0; i < N; i++) begin
                check($sformatf("rand_frames[%0d]", i), frames[i], want[i]);
                check($sformatf("rand_dones[%0d]", i), dones[i], frames[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
